// File: rtl/simd_addsub_sat_if.sv
// Handshake and datapath bundle for simd_addsub_sat. The master side drives operands and
// consumes results; the slave side is the arithmetic unit.
interface simd_addsub_sat_if #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned LANES = 4
);
  logic [LANES*DATAW-1:0] dataa_i;
  logic [LANES*DATAW-1:0] datab_i;
  logic                   sub_i;
  logic                   signed_i;
  logic                   sat_en_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [LANES*DATAW-1:0] sum_o;
  logic [LANES-1:0]       ovf_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   clr_sticky_i;
  logic [LANES-1:0]       ovf_sticky_o;

  modport master (
    output dataa_i, datab_i, sub_i, signed_i, sat_en_i, valid_i, ready_i, clr_sticky_i,
    input  ready_o, sum_o, ovf_o, valid_o, ovf_sticky_o
  );

  modport slave (
    input  dataa_i, datab_i, sub_i, signed_i, sat_en_i, valid_i, ready_i, clr_sticky_i,
    output ready_o, sum_o, ovf_o, valid_o, ovf_sticky_o
  );
endinterface

// File: rtl/simd_addsub_sat.sv
// Multi-lane saturating add/subtract with per-lane overflow, an optional valid/ready
// pipeline and a sticky per-lane overflow register.
module simd_addsub_sat #(
  parameter int unsigned DATAW        = 32,
  parameter int unsigned LANES        = 4,
  parameter int unsigned PIPES        = 1,
  parameter int unsigned BACKPRESSURE = 1
) (
  input logic              clk_i,
  input logic              rst_ni,
  simd_addsub_sat_if.slave bus
);
  localparam int unsigned PW = LANES * DATAW + LANES;

  logic [LANES*DATAW-1:0] lane_res;
  logic [LANES-1:0]       lane_ovf;
  logic                   down_ready;
  logic                   out_hs;
  logic [LANES-1:0]       sticky_q;

  assign down_ready = (BACKPRESSURE != 0) ? bus.ready_i : 1'b1;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATAW-1:0] a, b, bx, sat_val;
    logic [DATAW:0]   raw;
    logic             sa, sb, sr, ovf_s, ovf_u, ovf;

    assign a   = bus.dataa_i[l*DATAW +: DATAW];
    assign b   = bus.datab_i[l*DATAW +: DATAW];
    assign bx  = bus.sub_i ? ~b : b;
    assign raw = {1'b0, a} + {1'b0, bx} + {{DATAW{1'b0}}, bus.sub_i};
    assign sa  = a[DATAW-1];
    assign sb  = b[DATAW-1];
    assign sr  = raw[DATAW-1];

    // Signed overflow always saturates toward A's sign, for both add and sub.
    assign ovf_s = bus.sub_i ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    assign ovf_u = bus.sub_i ? ~raw[DATAW] : raw[DATAW];
    assign ovf   = bus.signed_i ? ovf_s : ovf_u;

    always_comb begin
      sat_val = '0;
      if (bus.signed_i) begin
        sat_val = sa ? {1'b1, {(DATAW-1){1'b0}}} : {1'b0, {(DATAW-1){1'b1}}};
      end else begin
        sat_val = bus.sub_i ? '0 : '1;
      end
    end

    assign lane_ovf[l]                = ovf;
    assign lane_res[l*DATAW +: DATAW] = (bus.sat_en_i && ovf) ? sat_val : raw[DATAW-1:0];
  end

  if (PIPES == 0) begin : g_comb
    assign bus.sum_o   = lane_res;
    assign bus.ovf_o   = lane_ovf;
    assign bus.valid_o = bus.valid_i;
    assign bus.ready_o = down_ready;
  end else begin : g_pipe
    logic [PIPES-1:0]    valid_q;
    logic [PIPES*PW-1:0] data_q;
    logic [PIPES:0]      chain_v;
    logic [(PIPES+1)*PW-1:0] chain_d;
    logic [PIPES:0]      stage_ready;

    // Entry k of the chain is the input of stage k; entry 0 is the fresh transaction.
    assign chain_v = {valid_q, bus.valid_i};
    assign chain_d = {data_q, lane_res, lane_ovf};

    // An empty stage is always ready, which squeezes out bubbles.
    always_comb begin
      stage_ready        = '0;
      stage_ready[PIPES] = down_ready;
      for (int k = int'(PIPES) - 1; k >= 0; k--) begin
        stage_ready[k] = ~valid_q[k] | stage_ready[k+1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        valid_q <= '0;
        data_q  <= '0;
      end else begin
        for (int unsigned k = 0; k < PIPES; k++) begin
          if (stage_ready[k]) begin
            valid_q[k]         <= chain_v[k];
            data_q[k*PW +: PW] <= chain_d[k*PW +: PW];
          end
        end
      end
    end

    assign bus.sum_o   = data_q[PIPES*PW-1 -: LANES*DATAW];
    assign bus.ovf_o   = data_q[(PIPES-1)*PW +: LANES];
    assign bus.valid_o = valid_q[PIPES-1];
    assign bus.ready_o = stage_ready[0];
  end

  assign out_hs = bus.valid_o & down_ready;

  // A clear coinciding with a handshake keeps only the new flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sticky_q <= '0;
    end else if (bus.clr_sticky_i) begin
      sticky_q <= out_hs ? bus.ovf_o : '0;
    end else if (out_hs) begin
      sticky_q <= sticky_q | bus.ovf_o;
    end
  end

  assign bus.ovf_sticky_o = sticky_q;
endmodule

// File: tb/tb_simd_addsub_sat.sv
// Randomized and directed bench for simd_addsub_sat (8-bit lanes, 4 lanes, 2 stages)
// scored against an integer-arithmetic reference model.
module tb_simd_addsub_sat;
  localparam int unsigned DW = 8;
  localparam int unsigned NL = 4;
  localparam int unsigned NP = 2;

  typedef struct {
    logic [NL*DW-1:0] sum;
    logic [NL-1:0]    ovf;
    int               cyc;
    bit               lat;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;

  simd_addsub_sat_if #(.DATAW(DW), .LANES(NL)) bus ();

  simd_addsub_sat #(
    .DATAW       (DW),
    .LANES       (NL),
    .PIPES       (NP),
    .BACKPRESSURE(1)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0 always ready, 1 pattern 1,0,0, 2 random, 3 never
  int clr_mode = 0;  // 0 low, 1 high, 2 random
  int pcnt = 0;
  exp_t q[$];
  logic [NL-1:0] sticky_m = '0;
  bit prev_stall = 1'b0;
  logic [NL*DW-1:0] prev_sum;
  logic [NL-1:0] prev_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_txn(input logic [NL*DW-1:0] a, input logic [NL*DW-1:0] b,
                                  input bit sub, input bit sgn, input bit sat,
                                  output logic [NL*DW-1:0] sum, output logic [NL-1:0] ovf);
    logic [DW-1:0] al, bl;
    longint av, bv, r, lo, hi, rv;
    sum = '0;
    ovf = '0;
    for (int l = 0; l < int'(NL); l++) begin
      al = a[l*DW +: DW];
      bl = b[l*DW +: DW];
      if (sgn) begin
        av = longint'($signed(al));
        bv = longint'($signed(bl));
        lo = -(longint'(1) << (DW - 1));
        hi = (longint'(1) << (DW - 1)) - 1;
      end else begin
        av = longint'(al);
        bv = longint'(bl);
        lo = 0;
        hi = (longint'(1) << DW) - 1;
      end
      r = sub ? av - bv : av + bv;
      ovf[l] = (r < lo) || (r > hi);
      rv = r;
      if (ovf[l] && sat) rv = (r > hi) ? hi : lo;
      sum[l*DW +: DW] = rv[DW-1:0];
    end
  endfunction

  // Downstream ready and sticky-clear generator, acting 2 time units after each edge.
  always @(posedge clk_i) begin
    #2;
    case (rdy_mode)
      0: bus.ready_i = 1'b1;
      1: bus.ready_i = (pcnt % 3 == 0);
      2: bus.ready_i = ($urandom_range(0, 3) != 0);
      default: bus.ready_i = 1'b0;
    endcase
    pcnt = (rdy_mode == 1) ? pcnt + 1 : 0;
    case (clr_mode)
      0: bus.clr_sticky_i = 1'b0;
      1: bus.clr_sticky_i = 1'b1;
      default: bus.clr_sticky_i = ($urandom_range(0, 7) == 0);
    endcase
  end

  // Scoreboard: everything sampled on the falling edge describes the next rising edge.
  always @(negedge clk_i) begin
    exp_t e, n;
    bit in_hs, out_hs;
    cyc++;
    if (!rst_ni) begin
      q.delete();
      sticky_m   = '0;
      prev_stall = 1'b0;
    end else begin
      check_eq("sticky", bus.ovf_sticky_o, sticky_m);
      if (prev_stall) begin
        check_eq("stall_valid", bus.valid_o, 1'b1);
        check_eq("stall_sum", bus.sum_o, prev_sum);
        check_eq("stall_ovf", bus.ovf_o, prev_ovf);
      end
      check_eq("ready_o", bus.ready_o, !((q.size() == int'(NP)) && !bus.ready_i));
      out_hs = bus.valid_o && bus.ready_i;
      in_hs  = bus.valid_i && bus.ready_o;
      if (out_hs) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", bus.valid_o, 1'b0);
        end else begin
          e = q.pop_front();
          check_eq("sum_o", bus.sum_o, e.sum);
          check_eq("ovf_o", bus.ovf_o, e.ovf);
          if (e.lat) check_eq("latency", cyc - e.cyc, NP);
        end
      end
      if (bus.clr_sticky_i) sticky_m = out_hs ? bus.ovf_o : '0;
      else if (out_hs) sticky_m = sticky_m | bus.ovf_o;
      if (in_hs) begin
        ref_txn(bus.dataa_i, bus.datab_i, bus.sub_i, bus.signed_i, bus.sat_en_i, n.sum, n.ovf);
        n.cyc = cyc;
        n.lat = (rdy_mode == 0);
        q.push_back(n);
      end
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_sum   = bus.sum_o;
      prev_ovf   = bus.ovf_o;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [NL*DW-1:0] a, input logic [NL*DW-1:0] b,
                      input bit sub, input bit sgn, input bit sat);
    bus.dataa_i  = a;
    bus.datab_i  = b;
    bus.sub_i    = sub;
    bus.signed_i = sgn;
    bus.sat_en_i = sat;
    bus.valid_i  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (bus.ready_o) break;
    end
    check_eq("accept", bus.ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (bus.valid_o) break;
    end
    check_eq("out_timeout", bus.valid_o, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_i);
      #1;
      if (q.size() == 0 && !bus.valid_o) break;
    end
    check_eq("drain", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni       = 1'b0;
    bus.valid_i  = 1'b0;
    bus.dataa_i  = '0;
    bus.datab_i  = '0;
    bus.sub_i    = 1'b0;
    bus.signed_i = 1'b0;
    bus.sat_en_i = 1'b0;
    bus.ready_i  = 1'b1;
    bus.clr_sticky_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    @(negedge clk_i);
    check_eq("rst_valid_o", bus.valid_o, 1'b0);
    check_eq("rst_sum_o", bus.sum_o, '0);
    check_eq("rst_ovf_o", bus.ovf_o, '0);
    check_eq("rst_sticky", bus.ovf_sticky_o, '0);
    check_eq("rst_ready_o", bus.ready_o, 1'b1);
    @(posedge clk_i);
    #1;

    // Signed add saturation
    send(32'hFF10_807F, 32'h0120_FF01, 1'b0, 1'b1, 1'b1);
    wait_out();
    check_eq("t1_sum", bus.sum_o, 32'h0030_807F);
    check_eq("t1_ovf", bus.ovf_o, 4'b0011);
    @(posedge clk_i);
    #1;

    // Unsigned subtract with borrow
    send(32'h8000_FF05, 32'h8000_0106, 1'b1, 1'b0, 1'b1);
    wait_out();
    check_eq("t2_sum", bus.sum_o, 32'h0000_FE00);
    check_eq("t2_ovf", bus.ovf_o, 4'b0001);
    @(posedge clk_i);
    #1;

    // Wrap mode, sticky set on the following cycle
    clr_mode = 1;
    @(posedge clk_i);
    #1 clr_mode = 0;
    send(32'h0000_007F, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    wait_out();
    check_eq("t3_sum", bus.sum_o, 32'h0000_0080);
    check_eq("t3_ovf", bus.ovf_o, 4'b0001);
    @(negedge clk_i);
    check_eq("t3_sticky", bus.ovf_sticky_o, 4'b0001);
    @(posedge clk_i);
    #1;

    // Sticky clear colliding with a handshake that carries lane 2 overflow
    check_eq("t5_sticky_pre", bus.ovf_sticky_o, 4'b0001);
    send(32'h007F_0000, 32'h0001_0000, 1'b0, 1'b1, 1'b1);
    @(posedge clk_i);
    #1 clr_mode = 1;
    @(posedge clk_i);
    #1 clr_mode = 0;
    @(negedge clk_i);
    check_eq("t5_sticky", bus.ovf_sticky_o, 4'b0100);
    @(posedge clk_i);
    #1;

    // Backpressure with the 1,0,0 ready pattern
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    rdy_mode = 0;
    drain();

    // Random traffic, random ready and sticky clears
    rdy_mode = 2;
    clr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    rdy_mode = 0;
    clr_mode = 0;
    drain();

    // Reset with two transactions in flight
    rdy_mode = 3;
    send($urandom, $urandom, 1'b0, 1'b1, 1'b1);
    send($urandom, $urandom, 1'b1, 1'b0, 1'b1);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("t6_valid_o", bus.valid_o, 1'b0);
    check_eq("t6_sum_o", bus.sum_o, '0);
    check_eq("t6_sticky", bus.ovf_sticky_o, '0);
    check_eq("t6_ready_o", bus.ready_o, 1'b1);
    rdy_mode = 0;
    repeat (6) @(negedge clk_i);
    check_eq("t6_no_ghost", bus.valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
